// File: rtl/cache_mem_responder.sv
// cache_mem_responder: latency-modelled word-read / byte-write backing store below the byte cache; MEM_RESP_STATS_EN builds the rd/wr counters
module cache_mem_responder #(
  parameter int ADDR_W = 13,
  parameter int RD_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rreq_from_cache,
  input  logic [ADDR_W-1:0] raddr_from_cache,
  output logic [31:0]       rdata_to_cache,
  output logic              rvalid_to_cache,
  input  logic              wreq_from_cache,
  input  logic [ADDR_W-1:0] waddr_from_cache,
  input  logic [7:0]        wdata_from_cache,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, REARM} state_t;
  state_t              r_state, w_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic [ADDR_W-3:0]   r_word;
  logic [31:0]         r_rdata, w_word;
  logic [7:0]          r_mem [DEPTH];
  // Bytes never written read back their power-on pattern, so storage needs no init block
  logic [DEPTH-1:0]    r_wr = '0;
  logic [ADDR_W-1:0]   w_baddr [4];
  logic                w_we;
  logic                w_unused;
  assign w_unused = ^raddr_from_cache[1:0];
  assign w_we = wreq_from_cache & ~reset;
  function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'(a >> 8);
  endfunction
  // Byte writes commit in every state; a write during reset is dropped
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[waddr_from_cache] <= wdata_from_cache;
      r_wr[waddr_from_cache] <= 1'b1;
    end
  end
  // Assemble the latched word, forwarding a write that commits on the capture edge
  always_comb begin
    w_word = '0;
    for (int i = 0; i < 4; i++) begin
      w_baddr[i] = {r_word, 2'(i)};
      w_word[8*i +: 8] = (w_we && waddr_from_cache == w_baddr[i]) ? wdata_from_cache :
                         r_wr[w_baddr[i]] ? r_mem[w_baddr[i]] : init_byte(w_baddr[i]);
    end
  end
  // Read FSM next state and latency counter
  always_comb begin
    w_next = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: if (rreq_from_cache) begin
        w_next = WAIT;
        w_cnt_next = 4'(RD_LATENCY - 1);
      end
      WAIT: if (!rreq_from_cache) w_next = IDLE;
            else if (r_cnt == 4'd0) w_next = RESP;
            else w_cnt_next = r_cnt - 4'd1;
      RESP: w_next = REARM;
      REARM: if (!rreq_from_cache) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // State, address latch and read-data capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_word <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_next;
      if (r_state == IDLE && rreq_from_cache) r_word <= raddr_from_cache[ADDR_W-1:2];
      if (r_state == WAIT && w_next == RESP) r_rdata <= w_word;
    end
  end
  assign rdata_to_cache = r_rdata;
  assign rvalid_to_cache = (r_state == RESP);
  assign busy = (r_state != IDLE);
`ifdef MEM_RESP_STATS_EN
  logic [15:0] r_rd_count, r_wr_count;
  // Saturating completed-read and committed-write counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == RESP && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      if (w_we && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
    end
  end
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: scoreboard bench for cache_mem_responder
module tb_cache_mem_responder;
  localparam int LAT = 4;
  logic        clk = 0, reset = 1;
  logic        rreq = 0, rvalid, wreq = 0, busy;
  logic [12:0] raddr = '0, waddr = '0;
  logic [7:0]  wdata = '0;
  logic [31:0] rdata;
  logic [15:0] rd_count, wr_count;
  int          checks = 0, errors = 0, pulses = 0;
  logic [31:0] q [$];

  cache_mem_responder #(.ADDR_W(13), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .rreq_from_cache(rreq), .raddr_from_cache(raddr),
    .rdata_to_cache(rdata), .rvalid_to_cache(rvalid),
    .wreq_from_cache(wreq), .waddr_from_cache(waddr), .wdata_from_cache(wdata),
    .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pops one expected word
  always @(negedge clk) begin
    if (rvalid) begin
      pulses++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rdata %08h expected no response", rdata);
      end else chk("rdata", rdata, q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d);
    wreq = 1; waddr = a; wdata = d;
    tick;
    wreq = 0;
  endtask

  task automatic rd(input logic [12:0] a, input logic [31:0] exp, input int hold);
    int n, p0;
    p0 = pulses;
    q.push_back(exp);
    rreq = 1; raddr = a; n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!rvalid && n < 20);
    chk("latency", n, LAT + 1);
    if (!rvalid) q.delete();
    for (int i = 0; i <= hold; i++) begin
      tick;
      chk("rearm_busy", busy, 1);
      chk("rearm_no_rvalid", rvalid, 0);
    end
    rreq = 0;
    tick;
    chk("idle_busy", busy, 0);
    chk("one_pulse", pulses - p0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    tick; tick;
    reset = 0;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    tick;
    rd(13'h004, 32'h07060504, 0);
    rd(13'h1F3, 32'hF2F3F0F1, 0);
    wr(13'h006, 8'hAB);
    rd(13'h004, 32'h07AB0504, 0);
    // reset during WAIT, with a concurrent write that must be dropped
    p0 = pulses;
    rreq = 1; raddr = 13'h100;
    tick; tick;
    chk("wait_busy", busy, 1);
    reset = 1; rreq = 0; wreq = 1; waddr = 13'h005; wdata = 8'h55;
    tick;
    reset = 0; wreq = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_rdata", rdata, 0);
    repeat (6) tick;
    chk("midrst_no_pulse", pulses - p0, 0);
    rd(13'h004, 32'h07AB0504, 0);
    rd(13'h00A, 32'h0B0A0908, 3);
    // write on the capture edge is forwarded, later write is not seen
    p0 = pulses;
    q.push_back(32'h07ABCD04);
    rreq = 1; raddr = 13'h004;
    tick;
    repeat (3) tick;
    wreq = 1; waddr = 13'h005; wdata = 8'hCD;
    tick;
    waddr = 13'h004; wdata = 8'hEE;
    tick;
    wreq = 0;
    chk("held_rdata", rdata, 32'h07ABCD04);
    rreq = 0;
    tick; tick;
    chk("col_pulse", pulses - p0, 1);
    rd(13'h007, 32'h07ABCDEE, 0);
    // counters
    reset = 1;
    tick;
    reset = 0;
    chk("rst2_rd_count", rd_count, 0);
    chk("rst2_wr_count", wr_count, 0);
    wr(13'h010, 8'h11);
    wr(13'h011, 8'h22);
    wr(13'h012, 8'h33);
    rd(13'h00C, 32'h0F0E0D0C, 0);
    rd(13'h010, 32'h13332211, 0);
`ifdef MEM_RESP_STATS_EN
    chk("rd_count", rd_count, 2);
    chk("wr_count", wr_count, 3);
`else
    chk("rd_count", rd_count, 0);
    chk("wr_count", wr_count, 0);
`endif
    tick;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
